// File: rtl/gate_jump_ctrl.sv
// Gate jump controller: latches one of NUM_GATES gate targets on request and steps the frog
// toward it by at most STEP_PX per axis per frame tick. GATE_JUMP_QUEUE_EN adds a one-deep buffer.
module gate_jump_ctrl #(
    parameter int unsigned NUM_GATES = 4,
    parameter int unsigned COORD_W   = 11,
    parameter int unsigned STEP_PX   = 8,
    parameter int unsigned START_X   = 320,
    parameter int unsigned START_Y   = 440,
    localparam int unsigned SEL_W    = $clog2(NUM_GATES)
) (
    input  logic                         CLK,
    input  logic                         RESETn,
    input  logic                         startOfFrame,
    input  logic                         jump_req,
    input  logic [SEL_W-1:0]             gate_sel,
    input  logic [NUM_GATES*COORD_W-1:0] gates_x,
    input  logic [NUM_GATES*COORD_W-1:0] gates_y,
    output logic                         jump_ack,
    output logic                         sel_err,
    output logic                         busy,
    output logic                         landed,
    output logic [COORD_W-1:0]           jumptoX,
    output logic [COORD_W-1:0]           jumptoY,
    output logic [COORD_W-1:0]           posX,
    output logic [COORD_W-1:0]           posY
);

    typedef enum logic [1:0] {StIdle, StMove, StLand} state_t;

    localparam logic [COORD_W:0]   STEP_V   = (COORD_W+1)'(STEP_PX);
    localparam logic [COORD_W-1:0] START_XV = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_YV = COORD_W'(START_Y);

    state_t             state;
    logic [COORD_W-1:0] sel_x;
    logic [COORD_W-1:0] sel_y;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;
    logic               sel_ok;
    logic               arrived;

`ifdef GATE_JUMP_QUEUE_EN
    logic               pend_valid;
    logic [COORD_W-1:0] pend_x;
    logic [COORD_W-1:0] pend_y;
`endif

    // Difference taken one bit wider so the clamp never wraps near either coordinate limit.
    function automatic logic [COORD_W-1:0] step_toward(input logic [COORD_W-1:0] pos,
                                                       input logic [COORD_W-1:0] tgt);
        logic [COORD_W:0] diff;
        logic [COORD_W:0] mv;
        diff = (pos < tgt) ? ({1'b0, tgt} - {1'b0, pos}) : ({1'b0, pos} - {1'b0, tgt});
        mv   = (diff > STEP_V) ? STEP_V : diff;
        return (pos < tgt) ? (pos + mv[COORD_W-1:0]) : (pos - mv[COORD_W-1:0]);
    endfunction

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < int'(NUM_GATES); i++) begin
            if (gate_sel == SEL_W'(i)) begin
                sel_x = gates_x[i*COORD_W +: COORD_W];
                sel_y = gates_y[i*COORD_W +: COORD_W];
            end
        end
    end

    always_comb begin
        sel_ok  = (32'(gate_sel) < NUM_GATES);
        next_x  = step_toward(posX, jumptoX);
        next_y  = step_toward(posY, jumptoY);
        arrived = (posX == jumptoX) && (posY == jumptoY);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= StIdle;
            posX     <= START_XV;
            posY     <= START_YV;
            jumptoX  <= START_XV;
            jumptoY  <= START_YV;
            jump_ack <= 1'b0;
            sel_err  <= 1'b0;
            landed   <= 1'b0;
            busy     <= 1'b0;
`ifdef GATE_JUMP_QUEUE_EN
            pend_valid <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
`endif
        end else begin
            jump_ack <= 1'b0;
            sel_err  <= 1'b0;
            landed   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (jump_req) begin
                        if (sel_ok) begin
                            jumptoX  <= sel_x;
                            jumptoY  <= sel_y;
                            jump_ack <= 1'b1;
                            busy     <= 1'b1;
                            state    <= StMove;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                StMove: begin
                    if (arrived) begin
                        landed <= 1'b1;
                        state  <= StLand;
                    end else if (startOfFrame) begin
                        posX <= next_x;
                        posY <= next_y;
                    end
`ifdef GATE_JUMP_QUEUE_EN
                    if (jump_req && sel_ok && !pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_x     <= sel_x;
                        pend_y     <= sel_y;
                        jump_ack   <= 1'b1;
                    end
`endif
                end
                StLand: begin
`ifdef GATE_JUMP_QUEUE_EN
                    if (pend_valid) begin
                        jumptoX    <= pend_x;
                        jumptoY    <= pend_y;
                        pend_valid <= 1'b0;
                        state      <= StMove;
                    end else if (jump_req && sel_ok) begin
                        // Empty buffer in LAND: load the new target straight away.
                        jumptoX  <= sel_x;
                        jumptoY  <= sel_y;
                        jump_ack <= 1'b1;
                        state    <= StMove;
                    end else begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
`else
                    busy  <= 1'b0;
                    state <= StIdle;
`endif
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_jump_ctrl.sv
// Bench for gate_jump_ctrl: per-segment stimulus, a jump-level reference model filling a
// scoreboard, and a monitor comparing pulses and per-cycle state. Honours GATE_JUMP_QUEUE_EN.
module tb_gate_jump_ctrl;

    // Five gates so that 3-bit selects 5..7 are out of range.
    localparam int NG     = 5;
    localparam int CW     = 11;
    localparam int STEP   = 8;
    localparam int SX     = 320;
    localparam int SY     = 440;
    localparam int SW     = $clog2(NG);
    localparam int SEGMAX = 400;

    logic            CLK = 1'b0;
    logic            RESETn = 1'b0;
    logic            startOfFrame = 1'b0;
    logic            jump_req = 1'b0;
    logic [SW-1:0]   gate_sel = '0;
    logic [NG*CW-1:0] gates_x = '0;
    logic [NG*CW-1:0] gates_y = '0;
    logic            jump_ack, sel_err, busy, landed;
    logic [CW-1:0]   jumptoX, jumptoY, posX, posY;

    gate_jump_ctrl #(
        .NUM_GATES (NG),
        .COORD_W   (CW),
        .STEP_PX   (STEP),
        .START_X   (SX),
        .START_Y   (SY)
    ) dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .startOfFrame (startOfFrame),
        .jump_req     (jump_req),
        .gate_sel     (gate_sel),
        .gates_x      (gates_x),
        .gates_y      (gates_y),
        .jump_ack     (jump_ack),
        .sel_err      (sel_err),
        .busy         (busy),
        .landed       (landed),
        .jumptoX      (jumptoX),
        .jumptoY      (jumptoY),
        .posX         (posX),
        .posY         (posY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {int cyc; bit ack; bit err; bit land;} ev_t;
    typedef struct {int cyc; bit busy; int px; int py; int jx; int jy;} st_t;
    ev_t evq[$];
    st_t stq[$];

    int errors = 0;
    int checks = 0;

    // Segment stimulus and expected per-cycle results.
    bit s_req[SEGMAX];
    int s_sel[SEGMAX];
    bit s_sof[SEGMAX];
    int s_gx[SEGMAX][NG];
    int s_gy[SEGMAX][NG];
    bit e_ack[SEGMAX], e_err[SEGMAX], e_land[SEGMAX], e_busy[SEGMAX];
    int e_px[SEGMAX], e_py[SEGMAX], e_jx[SEGMAX], e_jy[SEGMAX];

    int m_px, m_py, m_jx, m_jy;
    int gbx[NG] = '{40, 100, 320, 500, 600};
    int gby[NG] = '{40, 440, 360, 200, 100};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Position after k frame ticks of a straight clamped walk from p0 toward tg.
    function automatic int approach(input int p0, input int tg, input int k);
        int m;
        m = k * STEP;
        if (tg >= p0) return (tg - p0 <= m) ? tg : p0 + m;
        return (p0 - tg <= m) ? tg : p0 - m;
    endfunction

    task automatic model_reset();
        m_px = SX; m_py = SY; m_jx = SX; m_jy = SY;
    endtask

    task automatic snap(input int t, input bit b, input int px, input int py);
        e_busy[t] = b; e_px[t] = px; e_py[t] = py; e_jx[t] = m_jx; e_jy[t] = m_jy;
    endtask

    task automatic overrun();
        errors++; checks++;
        $display("FAIL model_overrun: jump still active at segment end (cycle %0d)", cyc);
    endtask

    // Jump-level model: a jump accepted at edge e lands after the n-th frame tick, where
    // n = ceil(max(|dx|,|dy|)/STEP); landed one edge later, idle (or next job) one after.
    task automatic build(input int n);
        int j;
        for (int t = 0; t < n; t++) begin e_ack[t] = 0; e_err[t] = 0; e_land[t] = 0; end
        j = 0;
        while (j < n) begin
            if (s_req[j] && s_sel[j] < NG) begin
                int  e;
                bit  chain;
                e = j;
                e_ack[e] = 1;
                m_jx = s_gx[e][s_sel[e]];
                m_jy = s_gy[e][s_sel[e]];
                chain = 1;
                while (chain) begin
                    int p0x, p0y, need, k, t, f, lst, r;
                    p0x = m_px; p0y = m_py;
                    need = (((iabs(m_jx - p0x) > iabs(m_jy - p0y)) ? iabs(m_jx - p0x)
                             : iabs(m_jy - p0y)) + STEP - 1) / STEP;
                    k = 0; t = e; f = -1;
                    snap(e, 1, p0x, p0y);
                    if (need == 0) f = e;
                    while (f < 0) begin
                        t++;
                        if (t >= n) break;
                        if (s_sof[t]) k++;
                        snap(t, 1, approach(p0x, m_jx, k), approach(p0y, m_jy, k));
                        if (k == need) f = t;
                    end
                    if (f < 0) begin
                        overrun(); j = n; chain = 0;
                    end else begin
                        m_px = m_jx; m_py = m_jy;
                        lst = f + 2;
                        r = -1;
`ifdef GATE_JUMP_QUEUE_EN
                        for (int q = e + 1; q <= lst && q < n; q++) begin
                            if (s_req[q] && s_sel[q] < NG) begin r = q; break; end
                        end
`endif
                        if (f + 1 < n) begin snap(f + 1, 1, m_px, m_py); e_land[f + 1] = 1; end
                        if (lst >= n) begin
                            overrun(); j = n; chain = 0;
                        end else if (r >= 0) begin
                            e_ack[r] = 1;
                            m_jx = s_gx[r][s_sel[r]];
                            m_jy = s_gy[r][s_sel[r]];
                            snap(lst, 1, m_px, m_py);
                            e = lst;
                        end else begin
                            snap(lst, 0, m_px, m_py);
                            j = lst + 1;
                            chain = 0;
                        end
                    end
                end
            end else begin
                if (s_req[j]) e_err[j] = 1;
                snap(j, 0, m_px, m_py);
                j++;
            end
        end
    endtask

    task automatic clear_seg(input int n);
        for (int t = 0; t < n; t++) begin
            s_req[t] = 0; s_sel[t] = 0; s_sof[t] = 0;
            for (int i = 0; i < NG; i++) begin s_gx[t][i] = gbx[i]; s_gy[t][i] = gby[i]; end
        end
    endtask

    task automatic gen_random(input int body, input int tail);
        int cx[NG], cy[NG];
        for (int i = 0; i < NG; i++) begin
            cx[i] = int'($urandom_range(0, 639)); cy[i] = int'($urandom_range(0, 479));
        end
        for (int t = 0; t < body + tail; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                int g;
                g = int'($urandom_range(0, NG - 1));
                cx[g] = int'($urandom_range(0, 639)); cy[g] = int'($urandom_range(0, 479));
            end
            for (int i = 0; i < NG; i++) begin s_gx[t][i] = cx[i]; s_gy[t][i] = cy[i]; end
            s_req[t] = (t < body) && ($urandom_range(0, 5) == 0);
            s_sel[t] = int'($urandom_range(0, 7));
            s_sof[t] = (t >= body) || ($urandom_range(0, 2) == 0);
        end
    endtask

    // Drive one cycle's inputs and queue what the DUT must show after the coming edge.
    task automatic apply(input int j);
        st_t s;
        ev_t v;
        jump_req     = s_req[j];
        gate_sel     = SW'(s_sel[j]);
        startOfFrame = s_sof[j];
        for (int i = 0; i < NG; i++) begin
            gates_x[i*CW +: CW] = CW'(s_gx[j][i]);
            gates_y[i*CW +: CW] = CW'(s_gy[j][i]);
        end
        s.cyc = cyc + 1; s.busy = e_busy[j];
        s.px = e_px[j]; s.py = e_py[j]; s.jx = e_jx[j]; s.jy = e_jy[j];
        stq.push_back(s);
        if (e_ack[j] || e_err[j] || e_land[j]) begin
            v.cyc = cyc + 1; v.ack = e_ack[j]; v.err = e_err[j]; v.land = e_land[j];
            evq.push_back(v);
        end
    endtask

    task automatic run_seg(input int n);
        for (int j = 0; j < n; j++) begin
            apply(j);
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        jump_req = 0; startOfFrame = 0;
        @(negedge CLK);
        #2 RESETn = 0;
        evq.delete(); stq.delete();
        model_reset();
        @(negedge CLK);
        RESETn = 1;
    endtask

    st_t mon_s;
    ev_t mon_v;
    always @(negedge CLK) begin
        if (RESETn) begin
            while (stq.size() > 0 && stq[0].cyc < cyc) begin
                mon_s = stq.pop_front();
                errors++; checks++;
                $display("FAIL trace_skipped: entry for cycle %0d never compared", mon_s.cyc);
            end
            if (stq.size() > 0 && stq[0].cyc == cyc) begin
                mon_s = stq.pop_front();
                chk("busy", int'(busy), int'(mon_s.busy));
                chk("posX", int'(posX), mon_s.px);
                chk("posY", int'(posY), mon_s.py);
                chk("jumptoX", int'(jumptoX), mon_s.jx);
                chk("jumptoY", int'(jumptoY), mon_s.jy);
            end
            if (jump_ack || sel_err || landed) begin
                if (evq.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_pulse @cycle %0d: ack=%0b sel_err=%0b landed=%0b, expected none",
                             cyc, jump_ack, sel_err, landed);
                end else begin
                    mon_v = evq.pop_front();
                    chk("pulse_cycle", cyc, mon_v.cyc);
                    chk("jump_ack", int'(jump_ack), int'(mon_v.ack));
                    chk("sel_err", int'(sel_err), int'(mon_v.err));
                    chk("landed", int'(landed), int'(mon_v.land));
                end
            end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
                mon_v = evq.pop_front();
                errors++; checks++;
                $display("FAIL missing_pulse @cycle %0d: no pulse, expected ack=%0b sel_err=%0b landed=%0b at %0d",
                         cyc, mon_v.ack, mon_v.err, mon_v.land, mon_v.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stop;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_posX", int'(posX), SX);
        chk("rst_posY", int'(posY), SY);
        chk("rst_jumptoX", int'(jumptoX), SX);
        chk("rst_jumptoY", int'(jumptoY), SY);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'({jump_ack, sel_err, landed}), 0);
        RESETn = 1;

        // Out-of-range selects in IDLE.
        clear_seg(10);
        s_req[1] = 1; s_sel[1] = 5;
        s_req[2] = 1; s_sel[2] = 7;
        s_req[5] = 1; s_sel[5] = 6;
        build(10);
        run_seg(10);

        // Gate 1 (100,440): 27 full steps then a 4-pixel step.
        clear_seg(80);
        s_req[1] = 1; s_sel[1] = 1;
        for (int t = 3; t < 80; t++) s_sof[t] = 1;
        build(80);
        run_seg(80);
        chk("gate1_posX", int'(posX), 100);
        chk("gate1_posY", int'(posY), 440);

        // Target equal to the current position: no frame tick needed.
        clear_seg(8);
        for (int t = 0; t < 8; t++) begin s_gx[t][3] = 100; s_gy[t][3] = 440; end
        s_req[1] = 1; s_sel[1] = 3;
        build(8);
        run_seg(8);

        // Gate 2 (320,360) with requests arriving mid-move.
        do_reset();
        clear_seg(200);
        s_req[1] = 1; s_sel[1] = 2;
        s_req[10] = 1; s_sel[10] = 0;
        s_req[15] = 1; s_sel[15] = 4;
        for (int t = 4; t < 200; t++) s_sof[t] = (t % 3 == 1);
        build(200);
        run_seg(200);
`ifdef GATE_JUMP_QUEUE_EN
        chk("gate2_final_posX", int'(posX), 40);
        chk("gate2_final_posY", int'(posY), 40);
`else
        chk("gate2_final_posX", int'(posX), 320);
        chk("gate2_final_posY", int'(posY), 360);
`endif

        // Asynchronous reset mid-move at (320,400).
        do_reset();
        clear_seg(40);
        s_req[1] = 1; s_sel[1] = 2;
        for (int t = 3; t < 40; t++) s_sof[t] = 1;
        build(40);
        stop = 39;
        for (int t = 0; t < 40; t++) begin
            if (e_busy[t] && e_py[t] == 400) begin stop = t; break; end
        end
        run_seg(stop + 1);
        chk("pre_reset_posY", int'(posY), 400);
        #2 RESETn = 0;
        evq.delete(); stq.delete();
        model_reset();
        #1;
        chk("async_rst_posX", int'(posX), SX);
        chk("async_rst_posY", int'(posY), SY);
        chk("async_rst_jumptoX", int'(jumptoX), SX);
        chk("async_rst_jumptoY", int'(jumptoY), SY);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge CLK);
        RESETn = 1;

        for (int seg = 0; seg < 8; seg++) begin
            gen_random(150, 200);
            build(350);
            run_seg(350);
        end

        jump_req = 0; startOfFrame = 0;
        repeat (2) @(negedge CLK);
        chk("leftover_pulses", evq.size(), 0);
        chk("leftover_trace", stq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
